// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: byte-framed SPI command slave; ports clk_in/sys_rst_n, sclk/cs_n/mosi/miso, write/action/read strobes, err_pulse/err_code
module spi_cmd_slave #(
  parameter int DATA_BYTES     = 2,
  parameter int NUM_REGS       = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk_in,
  input  logic                    sys_rst_n,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    wr_en,
  output logic [6:0]              wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    act_valid,
  output logic [5:0]              act_code,
  output logic                    rd_req,
  output logic [5:0]              rd_addr,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    err_pulse,
  output logic [1:0]              err_code
);
  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int KW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q;
  logic [7:0] rx_byte, tx_q, tx_d, rd_byte;
  logic [TW-1:0] to_q, to_d;
  logic [KW-1:0] k_q, k_d;
  logic [6:0] addr_q, addr_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d, wnext, rd_buf_q;
  logic wr_en_d, act_valid_d, rd_req_d, err_pulse_d;
  logic [6:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [5:0] act_code_d, rd_addr_d;
  logic [1:0] err_code_d;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, byte_done, short_byte, timeout, last;
  // index 1 is the synchronised level, index 2 its previous value for edge detection
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall = ~cs_q[1] & cs_q[2];
  assign cs_rise = cs_q[1] & ~cs_q[2];
  assign rx_byte = {rx_q, mosi_q[1]};
  // rising edges are not gated by cs so an 8th edge coinciding with cs rise still completes the byte
  assign byte_done = sclk_rise && bit_cnt_q == 4'd7;
  assign short_byte = cs_rise && !byte_done && bit_cnt_q != 4'd0 && bit_cnt_q != 4'd8;
  assign timeout = state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES);
  assign last = k_q == KW'(DATA_BYTES - 1);
  assign bit_cnt_d = cs_fall ? 4'd0 : (sclk_rise && bit_cnt_q != 4'd8) ? bit_cnt_q + 4'd1 : bit_cnt_q;
  assign to_d = (state_q == IDLE || cs_fall) ? '0 : (cs_q[1] && !timeout) ? to_q + TW'(1) : to_q;
  assign tx_d = cs_fall ? (state_q == RDATA ? rd_byte : 8'h00) : sclk_fall ? {tx_q[6:0], 1'b0} : tx_q;
  assign miso = ~cs_q[1] & tx_q[7];
  always_comb begin
    wnext = wbuf_q;
    rd_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (k_q == KW'(i)) begin
        wnext[8*i +: 8] = rx_byte;
        rd_byte = rd_buf_q[8*i +: 8];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    addr_d = addr_q;
    wbuf_d = wbuf_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    act_valid_d = 1'b0;
    act_code_d = act_code;
    rd_req_d = 1'b0;
    rd_addr_d = rd_addr;
    err_pulse_d = 1'b0;
    err_code_d = err_code;
    if (byte_done) begin
      if (state_q == IDLE) begin
        k_d = '0;
        if (rx_byte[7]) begin
          addr_d = rx_byte[6:0];
          state_d = WDATA;
        end else if (rx_byte[6]) begin
          rd_req_d = 1'b1;
          rd_addr_d = rx_byte[5:0];
          state_d = RDATA;
        end else begin
          act_valid_d = 1'b1;
          act_code_d = rx_byte[5:0];
        end
      end else begin
        wbuf_d = wnext;
        k_d = last ? k_q : k_q + KW'(1);
        state_d = last ? IDLE : state_q;
        if (last && state_q == WDATA) begin
          wr_en_d = 32'(addr_q) < NUM_REGS;
          err_pulse_d = !(32'(addr_q) < NUM_REGS);
          wr_addr_d = wr_en_d ? addr_q : wr_addr;
          wr_data_d = wr_en_d ? wnext : wr_data;
          err_code_d = wr_en_d ? err_code : 2'b11;
        end
      end
    end else if (short_byte || timeout) begin
      err_pulse_d = 1'b1;
      err_code_d = short_byte ? 2'b01 : 2'b10;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_q <= '0;
      cs_q <= '1;
      mosi_q <= '0;
      state_q <= IDLE;
      bit_cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      to_q <= '0;
      k_q <= '0;
      addr_q <= '0;
      wbuf_q <= '0;
      rd_buf_q <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      act_valid <= 1'b0;
      act_code <= '0;
      rd_req <= 1'b0;
      rd_addr <= '0;
      err_pulse <= 1'b0;
      err_code <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q <= sclk_rise ? rx_byte[6:0] : rx_q;
      tx_q <= tx_d;
      to_q <= to_d;
      k_q <= k_d;
      addr_q <= addr_d;
      wbuf_q <= wbuf_d;
      rd_buf_q <= rd_req ? rd_data : rd_buf_q;
      wr_en <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      act_valid <= act_valid_d;
      act_code <= act_code_d;
      rd_req <= rd_req_d;
      rd_addr <= rd_addr_d;
      err_pulse <= err_pulse_d;
      err_code <= err_code_d;
    end
  end
endmodule

// File: tb/tb_spi_cmd_slave.sv
// tb_spi_cmd_slave: directed self-checking bench for spi_cmd_slave (2-byte and 3-byte payload builds)
`timescale 1ns/1ps
module tb_spi_cmd_slave;
  logic clk_in = 1'b0, sys_rst_n = 1'b0, rst3_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [15:0] rd_data = 16'h4001;
  logic [23:0] rd_data3 = 24'h0;
  logic miso, wr_en, act_valid, rd_req, err_pulse;
  logic [6:0] wr_addr;
  logic [15:0] wr_data;
  logic [5:0] act_code, rd_addr;
  logic [1:0] err_code;
  logic miso3, wr_en3, act_valid3, rd_req3, err_pulse3;
  logic [6:0] wr_addr3;
  logic [23:0] wr_data3;
  logic [5:0] act_code3, rd_addr3;
  logic [1:0] err_code3;
  int total = 0, bad = 0;
  int n_wr = 0, n_act = 0, n_rd = 0, n_err = 0, n_wr3 = 0, viol = 0;
  logic p_wr = 0, p_act = 0, p_rd = 0, p_err = 0;
  logic [7:0] r;
  spi_cmd_slave #(.DATA_BYTES(2)) dut (
    .clk_in(clk_in), .sys_rst_n(sys_rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .act_valid(act_valid), .act_code(act_code),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .err_pulse(err_pulse), .err_code(err_code)
  );
  spi_cmd_slave #(.DATA_BYTES(3)) dut3 (
    .clk_in(clk_in), .sys_rst_n(rst3_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .act_valid(act_valid3), .act_code(act_code3),
    .rd_req(rd_req3), .rd_addr(rd_addr3), .rd_data(rd_data3), .err_pulse(err_pulse3), .err_code(err_code3)
  );
  always #10 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    n_wr <= n_wr + int'(wr_en);
    n_act <= n_act + int'(act_valid);
    n_rd <= n_rd + int'(rd_req);
    n_err <= n_err + int'(err_pulse);
    n_wr3 <= n_wr3 + int'(wr_en3);
    p_wr <= wr_en;
    p_act <= act_valid;
    p_rd <= rd_req;
    p_err <= err_pulse;
    viol <= viol + int'($countones({wr_en, act_valid, rd_req, err_pulse}) > 1
                 || $countones({wr_en3, act_valid3, rd_req3, err_pulse3}) > 1
                 || (wr_en && p_wr) || (act_valid && p_act) || (rd_req && p_rd) || (err_pulse && p_err));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] rb);
    rb = 8'h00;
    cs_n = 1'b0;
    #60;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      #60 sclk = 1'b1;
      #59 rb = {rb[6:0], miso};
      #1 sclk = 1'b0;
    end
    #60 cs_n = 1'b1;
    #240;
  endtask
  initial begin
    #43;
    chk("reset_outputs", {miso, wr_en, wr_addr, wr_data, act_valid, act_code}, 32'h0);
    chk("reset_outputs2", {rd_req, rd_addr, err_pulse, err_code}, 32'h0);
    #20 sys_rst_n = 1'b1;
    #100;
    send_byte(8'h91, 8, r);
    chk("idle_miso", r, 8'h00);
    send_byte(8'h64, 8, r);
    send_byte(8'h00, 8, r);
    chk("t1_wr_cnt", n_wr, 1);
    chk("t1_wr_addr", wr_addr, 7'h11);
    chk("t1_wr_data", wr_data, 16'h0064);
    chk("t1_other", n_act + n_rd + n_err, 0);
    send_byte(8'h06, 8, r);
    chk("t2_act_cnt", n_act, 1);
    chk("t2_act_code", act_code, 6'h06);
    chk("t2_wr_cnt", n_wr, 1);
    send_byte(8'h9E, 8, r);
    send_byte(8'h32, 8, r);
    send_byte(8'h00, 8, r);
    chk("t2_wr_cnt2", n_wr, 2);
    chk("t2_wr_addr", wr_addr, 7'h1E);
    chk("t2_wr_data", wr_data, 16'h0032);
    send_byte(8'h5C, 8, r);
    chk("t3_rd_cnt", n_rd, 1);
    chk("t3_rd_addr", rd_addr, 6'h1C);
    send_byte(8'hFF, 8, r);
    chk("t3_miso_b0", r, 8'h01);
    send_byte(8'h00, 8, r);
    chk("t3_miso_b1", r, 8'h40);
    chk("t3_wr_cnt", n_wr, 2);
    send_byte(8'h07, 8, r);
    chk("t3_back_idle", n_act, 2);
    chk("t3_act_code", act_code, 6'h07);
    send_byte(8'h93, 5, r);
    chk("t4_err_cnt", n_err, 1);
    chk("t4_err_code", err_code, 2'b01);
    send_byte(8'h93, 8, r);
    send_byte(8'h3C, 8, r);
    send_byte(8'h00, 8, r);
    chk("t4_wr_cnt", n_wr, 3);
    chk("t4_wr_addr", wr_addr, 7'h13);
    chk("t4_wr_data", wr_data, 16'h003C);
    send_byte(8'h9C, 8, r);
    send_byte(8'h01, 8, r);
    #1100000;
    chk("t5_err_cnt", n_err, 2);
    chk("t5_err_code", err_code, 2'b10);
    chk("t5_wr_cnt", n_wr, 3);
    send_byte(8'h40, 8, r);
    chk("t5_rd_cnt", n_rd, 2);
    chk("t5_rd_addr", rd_addr, 6'h00);
    send_byte(8'h00, 8, r);
    chk("t5_miso_b0", r, 8'h01);
    send_byte(8'h00, 8, r);
    send_byte(8'hA5, 8, r);
    send_byte(8'h11, 8, r);
    send_byte(8'h22, 8, r);
    chk("t6_err_cnt", n_err, 3);
    chk("t6_err_code", err_code, 2'b11);
    chk("t6_wr_cnt", n_wr, 3);
    chk("t6_wr_hold", wr_addr, 7'h13);
    rst3_n = 1'b1;
    #100;
    send_byte(8'h81, 8, r);
    send_byte(8'h01, 8, r);
    rst3_n = 1'b0;
    #1;
    chk("t6_rst_out", {miso3, wr_en3, wr_addr3, wr_data3}, 32'h0);
    chk("t6_rst_out2", {act_valid3, act_code3, rd_req3, rd_addr3, err_pulse3, err_code3}, 32'h0);
    #39 rst3_n = 1'b1;
    #100;
    send_byte(8'h81, 8, r);
    send_byte(8'h01, 8, r);
    send_byte(8'h02, 8, r);
    send_byte(8'h03, 8, r);
    chk("t6_wr3_cnt", n_wr3, 1);
    chk("t6_wr3_addr", wr_addr3, 7'h01);
    chk("t6_wr3_data", wr_data3, 24'h030201);
    chk("strobe_excl", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
